instr_prefetch_buffer: RTL
==========================

Name: instr_prefetch_buffer

Overview:
- Sits directly upstream of the fetch stage, between a handshaked instruction memory and the decode-side consumer.
- Issues sequential word fetch requests and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Discards stale in-flight responses when execute redirects the PC on a taken branch or jump (PCSrcE / PCTargetE).
- Decouples instruction memory latency from the pipeline.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2; also the in-flight request credit limit
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
redirect_valid  input  1  taken branch/jump from execute (PCSrcE)
redirect_pc  input  32  target PC (PCTargetE)
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  32  fetch word address
mem_req_ready  input  1  memory accepts request
mem_rsp_valid  input  1  response valid; in order, ≥1 cycle after acceptance, always accepted
mem_rsp_data  input  32  returned instruction
instr_valid  output  1  FIFO head valid
instr_data  output  32  head instruction (InstrD source)
instr_pc  output  32  head PC (PCD source; PCPlus4D = instr_pc+4 downstream)
instr_ready  input  1  consumer pops head

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-low.
- Reset (rst=0 at posedge):
  - fetch_pc = rsp_pc = RESET_PC; FIFO empty; outstanding = drop_cnt = 0.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - Reset mid-operation abandons all state; responses arriving while rst=0 are ignored.
  - Responses to pre-reset requests are not tracked after reset; the memory is reset together with this block.
- Issue:
  - mem_req_valid = rst & ~redirect_valid & (occupancy + outstanding < DEPTH).
  - mem_req_addr = fetch_pc. Address is held stable while valid & ~ready.
  - On valid & ready: fetch_pc += 4 (mod 2^32), outstanding += 1.
- Response (mem_rsp_valid=1):
  - outstanding -= 1 (net with a same-cycle issue).
  - If drop_cnt>0: drop_cnt -= 1, data discarded.
  - Else push {rsp_pc, mem_rsp_data}; rsp_pc += 4.
- Credit rule guarantees no overflow: a push never finds the FIFO full. Response with outstanding=0 is illegal (assertion).
- Output:
  - instr_valid = occupancy≠0.
  - instr_data/instr_pc = head entry when valid, else 0.
  - Pushed entry is visible the cycle after mem_rsp_valid (1-cycle pass latency).
  - Pop on instr_valid & instr_ready. Push and pop in the same cycle leave occupancy unchanged.
- Redirect (redirect_valid=1 at posedge, highest priority after reset):
  - FIFO cleared; a same-cycle pop and push are both ignored.
  - fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − mem_rsp_valid. All remaining in-flight responses become stale.
  - No request issues in the redirect cycle. The first request from the new PC is offered the next cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counters: occupancy 0..DEPTH, outstanding 0..DEPTH, drop_cnt ≤ outstanding. Wrap of fetch_pc past 32'hFFFF_FFFC goes to 0.

Test Plan:
- Reset then release, mem_req_ready=1, memory latency 1 → req addrs 0x0,0x4,0x8…; first instr_valid with instr_pc=0x0 two cycles after first acceptance; instr_pc increments by 4.
- instr_ready=0, DEPTH=4 → exactly 4 requests accepted (0x0–0xC); mem_req_valid then stays 0. Occupancy=4, head pc 0x0. Raise instr_ready → one pop per cycle; issue resumes at 0x10.
- Two requests in flight (latency 3), redirect to 0x100 → both responses discarded, FIFO empty; next instr_pc=0x100. redirect_pc=0x103 → fetch at 0x100.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty, drop_cnt=outstanding−1; no stale PC ever reaches instr_pc.
- mem_req_ready=0 for 5 cycles → mem_req_valid=1 with addr held constant; accepted once ready rises.
- rst=0 mid-stream with 3 entries buffered → next cycle instr_valid=0, outputs 0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch requests feeding a PC-tagged FIFO.
// Redirects flush the FIFO and turn every in-flight response stale.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW:0]   credit_sum;
    logic [31:0]   target_pc;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign target_pc      = {redirect_pc[31:2], 2'b00};

    // Buffered plus in-flight words never exceed DEPTH, so pushes always fit.
    assign credit_sum    = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem_req_valid = rst & ~redirect_valid
                         & (credit_sum < (CW + 1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;

    assign issue = mem_req_valid & mem_req_ready;
    assign push  = mem_rsp_valid & (drop_cnt == '0);
    assign pop   = instr_valid & instr_ready;

    assign instr_valid = (occupancy != '0);
    assign instr_data  = instr_valid ? fifo[rd_ptr].data : '0;
    assign instr_pc    = instr_valid ? fifo[rd_ptr].pc   : '0;

    always_ff @(posedge clk) begin
        if (rst && !redirect_valid && push) begin
            fifo[wr_ptr] <= '{pc: rsp_pc, data: mem_rsp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
        end else if (redirect_valid) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            // The response landing now is discarded; everything else is stale.
            outstanding <= outstanding - CW'(mem_rsp_valid);
            drop_cnt    <= outstanding - CW'(mem_rsp_valid);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(issue) - CW'(mem_rsp_valid);
            if (mem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    rsp_needs_credit: assert property (
        @(posedge clk) disable iff (!rst)
        mem_rsp_valid |-> (outstanding != '0)
    );

endmodule
